// File: rtl/mux8x1_arbiter_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // One-hot grant vector for a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8x1_arbiter_rr_pick.sv
// Round-robin pick: first set request bit scanning from ptr upward with
// wrap, optionally skipping one index (the current holder).
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    input  logic       mask_en,
    input  logic [2:0] mask_idx,
    output logic       found,
    output logic [2:0] idx
);

    // Scan the eight positions in priority order, keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            logic [2:0] cand;
            cand = ptr + SEL_W'(i);
            if (!found && req[cand] && !(mask_en && (cand == mask_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux8x1_arbiter.sv
// Round-robin arbiter driving the select/enable of a shared 8:1 mux.
// Optional build macro ARB_TIMEOUT_EN: a holder that keeps requesting is
// rotated out after MAX_HOLD cycles when someone else is waiting.
module mux8x1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] select,
    output logic       enable,
    output logic       busy
);

    arb_state_t state;
    logic [2:0] ptr;
    logic       pick_found;
    logic [2:0] pick_idx;
    logic       holder_req;
    logic       timeout_hit;
    logic       do_grant;
    logic       do_idle;

    // While granting, the holder is masked so a release hands straight over
    // to someone else and a re-request ranks last.
    rr_pick u_pick (
        .req      (req),
        .ptr      (ptr),
        .mask_en  (state == GRANT),
        .mask_idx (select),
        .found    (pick_found),
        .idx      (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;

    // Counts cycles the current grant has been held; clears on a new grant
    // and when the hold window expires with nobody else waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (do_grant || timeout_hit) begin
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    assign timeout_hit = (state == GRANT) && holder_req &&
                         (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    logic unused_hold;
    assign unused_hold = ^{HOLD_W'(MAX_HOLD)};
    assign timeout_hit = 1'b0;
`endif

    // Decide this cycle's transition from the registered state and live req.
    always_comb begin
        holder_req = req[select];
        do_grant   = 1'b0;
        do_idle    = 1'b0;
        if (state == IDLE) begin
            do_grant = pick_found;
        end else begin
            do_grant = pick_found && (!holder_req || timeout_hit);
            do_idle  = !pick_found && !holder_req;
        end
    end

    // Arbiter FSM with registered grant/select/enable/busy.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            select <= '0;
            enable <= 1'b0;
            busy   <= 1'b0;
            ptr    <= '0;
        end else if (do_grant) begin
            state  <= GRANT;
            grant  <= onehot(pick_idx);
            select <= pick_idx;
            enable <= 1'b1;
            busy   <= 1'b1;
            ptr    <= pick_idx + 3'd1;
        end else if (do_idle) begin
            state  <= IDLE;
            grant  <= '0;
            enable <= 1'b0;
            busy   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux8x1_arbiter.sv
// Self-checking bench for mux8x1_arbiter: directed vector table, a hold /
// timeout sequence, then randomized traffic against a behavioural model.
module tb_mux8x1_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] select;
    logic       enable;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    mux8x1_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .grant  (grant),
        .select (select),
        .enable (enable),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       en;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] g,
                                 input logic [2:0] s, input logic e);
        check({tag, " grant"}, grant, g);
        check({tag, " select"}, {5'd0, select}, {5'd0, s});
        check({tag, " enable"}, {7'd0, enable}, {7'd0, e});
        check({tag, " busy"}, {7'd0, busy}, {7'd0, e});
    endtask

    // Apply inputs away from the edge, let one rising edge pass, settle.
    task automatic cycle(input logic r, input logic [7:0] q);
        reset = r;
        req   = q;
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural reference model ----------------
    int m_holder;   // -1 when idle
    int m_ptr;
    int m_sel;
    int m_held;     // cycles the current grant has been visible

    function automatic int pick(input logic [7:0] r, input int start, input int excl);
        for (int i = 0; i < 8; i++) begin
            int k;
            k = (start + i) % 8;
            if (r[k] && k != excl) return k;
        end
        return -1;
    endfunction

    task automatic model_grant(input int k);
        m_holder = k;
        m_sel    = k;
        m_ptr    = (k + 1) % 8;
        m_held   = 1;
    endtask

    task automatic model_step(input logic r, input logic [7:0] q);
        int other;
        bit timeout_on;
`ifdef ARB_TIMEOUT_EN
        timeout_on = 1'b1;
`else
        timeout_on = 1'b0;
`endif
        if (r) begin
            m_holder = -1;
            m_ptr    = 0;
            m_sel    = 0;
            m_held   = 0;
        end else if (m_holder < 0) begin
            other = pick(q, m_ptr, -1);
            if (other >= 0) model_grant(other);
        end else begin
            other = pick(q, m_ptr, m_holder);
            if (!q[m_holder]) begin
                if (other >= 0) model_grant(other);
                else m_holder = -1;
            end else if (timeout_on && m_held >= MAX_HOLD) begin
                if (other >= 0) model_grant(other);
                else m_held = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    initial begin
        logic [7:0] exp_g;
        logic [7:0] rq;
        reset = 1'b1;
        req   = 8'h00;

        // Directed vectors: inputs for one edge, outputs expected after it.
        vecs.push_back('{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0}); // reset, all requesting
        vecs.push_back('{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1}); // first grant from ptr 0
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 8'h10, 8'h10, 3'd4, 1'b1}); // single request
        vecs.push_back('{1'b0, 8'h10, 8'h10, 3'd4, 1'b1});
        vecs.push_back('{1'b0, 8'h10, 8'h10, 3'd4, 1'b1});
        vecs.push_back('{1'b0, 8'h10, 8'h10, 3'd4, 1'b1});
        vecs.push_back('{1'b0, 8'h10, 8'h10, 3'd4, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd4, 1'b0}); // drop: select holds 4
        vecs.push_back('{1'b0, 8'h05, 8'h01, 3'd0, 1'b1}); // ptr 5 wraps to 0
        vecs.push_back('{1'b0, 8'h05, 8'h01, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 8'h05, 8'h01, 3'd0, 1'b1});
        vecs.push_back('{1'b0, 8'h04, 8'h04, 3'd2, 1'b1}); // handoff, no bubble
        vecs.push_back('{1'b0, 8'h04, 8'h04, 3'd2, 1'b1});
        vecs.push_back('{1'b0, 8'h01, 8'h01, 3'd0, 1'b1}); // swap back to 0
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 8'h80, 8'h80, 3'd7, 1'b1}); // grant 7, ptr -> 0
        vecs.push_back('{1'b0, 8'h81, 8'h80, 3'd7, 1'b1}); // 0 waits, no preempt
        vecs.push_back('{1'b0, 8'h01, 8'h01, 3'd0, 1'b1}); // release 7 -> 0
        vecs.push_back('{1'b0, 8'h80, 8'h80, 3'd7, 1'b1}); // release 0 -> 7
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd7, 1'b0});
        vecs.push_back('{1'b0, 8'h08, 8'h08, 3'd3, 1'b1});
        vecs.push_back('{1'b0, 8'h08, 8'h08, 3'd3, 1'b1});
        vecs.push_back('{1'b1, 8'h08, 8'h00, 3'd0, 1'b0}); // reset mid-grant
        vecs.push_back('{1'b0, 8'h08, 8'h08, 3'd3, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 3'd3, 1'b0});

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].req);
            check_outputs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].en);
        end

        // Two requesters held constantly: rotation only under the timeout build.
        for (int c = 0; c < 12; c++) begin
`ifdef ARB_TIMEOUT_EN
            exp_g = ((c / MAX_HOLD) % 2 == 1) ? 8'h02 : 8'h01;
`else
            exp_g = 8'h01;
`endif
            cycle(1'b0, 8'h03);
            check_outputs($sformatf("hold%0d", c), exp_g, (exp_g == 8'h02) ? 3'd1 : 3'd0, 1'b1);
        end
        cycle(1'b0, 8'h00);
        check_outputs("hold_release", 8'h00, 3'd0, 1'b0);

        // Randomized traffic against the reference model.
        cycle(1'b1, 8'h00);
        model_step(1'b1, 8'h00);
        rq = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            logic r;
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rq = 8'($urandom) & 8'($urandom);
            end else if ($urandom_range(0, 5) == 0 && m_holder >= 0) begin
                rq[m_holder] = 1'b0;
            end
            cycle(r, rq);
            model_step(r, rq);
            exp_g = (m_holder < 0) ? 8'h00 : (8'h01 << m_holder);
            check_outputs($sformatf("rnd%0d", n), exp_g, 3'(m_sel), m_holder >= 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux8x1_arbiter.md
Name: mux8x1_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux datapath between 8 requesters.
- Drives the mux `select[2:0]` and `enable` directly, plus a one-hot grant back to the requesters.
- Sits between requester logic and the `mux8x1`; it is the sole source of the mux's select/enable.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant is held while others wait (used only with ARB_TIMEOUT_EN); legal range 2..256.
- HOLD_W, $clog2(MAX_HOLD+1), width of the hold counter (derived; do not override).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i = requester i (maps to mux input a..h).
- grant  output  8  one-hot grant; all zero when idle.
- select  output  3  mux select; index of the current/last granted requester.
- enable  output  1  mux enable; high exactly while grant is non-zero.
- busy  output  1  high when in GRANT state (equal to enable, kept for status use).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: grant=0, select=0, enable=0, busy=0, state=IDLE, rotating pointer ptr=0, hold counter=0.
- ptr is the first index searched. After granting index k, ptr=(k+1) mod 8, with wrap 7->0.
- Pick function: first set bit of req scanning ptr, ptr+1, …, wrapping mod 8.
- IDLE:
  - If req!=0, register grant to the pick result; enable/grant/select are valid on the next edge. Latency is 1 cycle from req to grant.
  - If req==0, stay IDLE.
- GRANT, holder index s:
  - Grant is held while req[s]=1.
  - When req[s]=0 is sampled and other requests are pending (req excluding s non-zero), move straight to the next pick on the next edge. There is no idle bubble.
  - When req[s]=0 is sampled and no other request is pending, go to IDLE on the next edge: enable=0, grant=0, select holds s.
- Requests from non-holders never preempt, except via timeout (optional feature).
- Simultaneous release and re-request of other bits: the pick uses the same-cycle req vector with bit s masked out.
- Holder drops and reasserts req[s] in consecutive cycles: the drop is a release; s is re-arbitrated with the lowest round-robin priority.
- Outputs are registered; grant is always one-hot or zero. No combinational path from req to outputs.
- select changes only on a new grant, never while enable=1.
- Reset asserted mid-grant: all outputs return to reset values on that edge, regardless of req.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The hold counter increments each GRANT cycle and clears on every new grant.
  - When the counter reaches MAX_HOLD and another request is pending, the grant rotates to the next pick on the next edge even if req[s]=1.
  - If no other request is pending, the grant stays and the counter clears.
- Undefined: no counter is present; the holder keeps the grant until it drops req.

Decomposition:
- Package mux_arb_pkg:
  - N_REQ=8, SEL_W=3.
  - State enum {IDLE, GRANT}.
  - onehot-from-index helper function.
- Sub-module rr_pick (combinational):
  - Inputs: req[7:0], ptr[2:0], mask index.
  - Outputs: found, idx[2:0].
  - Instantiated once.

Test Plan:
- Reset: hold reset 2 cycles with req=8'hFF -> grant=8'h00, select=0, enable=0; first grant after release is grant=8'h01.
- Single request: req=8'h10 at cycle t -> at t+1 grant=8'h10, select=4, enable=1. Drop req at t+5 -> at t+6 enable=0, grant=0, select=4.
- Back-to-back handoff:
  - Apply req=8'h05 -> grant=8'h01.
  - Clear bit0 after 3 cycles -> next cycle grant=8'h04, select=2, enable never low.
  - Re-raise bit0 and drop bit2 -> grant=8'h01.
- Pointer wrap: after a grant to 7 is released with req=8'h81 still pending bit0 -> grant=8'h01, select=0. A following release with req=8'h80 -> grant=8'h80.
- Reset mid-grant: grant=8'h08 active, assert reset for 1 cycle with req held -> grant=0, enable=0 that edge; next edge grant=8'h08 (ptr=0 scan, only bit3 set).
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4), req=8'h03 held constant:
  - Expected: grant alternates 8'h01 x4, 8'h02 x4, ….
  - Without the macro: grant stays 8'h01 indefinitely.
